// File: rtl/wavetable_voice.sv
// wavetable_voice
//   Single-voice wavetable oscillator. A phase accumulator walks a
//   runtime-loadable segment table. A gate FSM applies full gain on note_on
//   and an exponential release after note_off. The sample is scaled by the
//   envelope gain in a two-stage pipeline.
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-high; the table RAM is not cleared
//   note_on      1-cycle strobe: start/retrigger, captures phase_inc
//   note_off     1-cycle strobe: begin release (ignored in IDLE, loses to note_on)
//   phase_inc    per-clock phase step, sampled only with note_on
//   tbl_we       table write enable
//   tbl_addr     table write address
//   tbl_wdata    table write data (signed)
//   audio_out    signed scaled sample, registered
//   busy         1 while the FSM is not IDLE
//   period_wrap  1-cycle pulse after the phase accumulator carries out
module wavetable_voice #(
  parameter int DATA_W      = 32,
  parameter int SEG_ADDR_W  = 6,
  parameter int ACTIVE_SEGS = 64,
  parameter int PHASE_W     = 24,
  parameter int ENV_W       = 16,
  parameter int DECAY_SHIFT = 4,
  parameter int DECAY_DIV   = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  note_on,
  input  logic                  note_off,
  input  logic [PHASE_W-1:0]    phase_inc,
  input  logic                  tbl_we,
  input  logic [SEG_ADDR_W-1:0] tbl_addr,
  input  logic [DATA_W-1:0]     tbl_wdata,
  output logic [DATA_W-1:0]     audio_out,
  output logic                  busy,
  output logic                  period_wrap
);

  localparam int SEG_COUNT = 2 ** SEG_ADDR_W;
  localparam int DIV_W     = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam int PW        = DATA_W + ENV_W + 1;

  localparam logic [ENV_W:0]      GAIN_ONE = {1'b1, {ENV_W{1'b0}}};
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(DECAY_DIV - 1);
  localparam logic [SEG_ADDR_W:0] ACT_LIM  = (SEG_ADDR_W + 1)'(ACTIVE_SEGS);

  typedef enum logic [1:0] {IDLE, PLAY, RELEASE} state_t;

  state_t                 state, state_nx;
  logic [PHASE_W-1:0]     phase, inc_reg;
  logic [ENV_W:0]         gain, gain_shr, gain_step, gain_dec;
  logic [DIV_W-1:0]       div_cnt;
  logic                   decay_tick;

  logic [DATA_W-1:0]      mem [SEG_COUNT];
  logic [SEG_ADDR_W-1:0]  seg;
  logic                   seg_active;

  logic signed [DATA_W-1:0] s1_smp;
  logic [ENV_W:0]           s1_gain;
  logic signed [PW-1:0]     smp_x, gain_x, prod;

  // Release step: shrink by gain>>DECAY_SHIFT, but at least 1 so the tail
  // reaches zero instead of stalling once the shift underflows.
  assign gain_shr   = gain >> DECAY_SHIFT;
  assign gain_step  = (gain_shr == '0) ? (ENV_W + 1)'(1) : gain_shr;
  assign gain_dec   = gain - gain_step;
  assign decay_tick = (state == RELEASE) && (div_cnt == DIV_LAST);

  assign busy = (state != IDLE);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (note_on) state_nx = PLAY;
      PLAY:    if (note_on) state_nx = PLAY;
               else if (note_off) state_nx = RELEASE;
      RELEASE: if (note_on) state_nx = PLAY;
               else if (decay_tick && gain_dec == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ------------------------------------------------- phase / envelope
  // note_on retriggers from any state and wins over note_off.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase       <= '0;
      inc_reg     <= '0;
      gain        <= '0;
      div_cnt     <= '0;
      period_wrap <= 1'b0;
    end else if (note_on) begin
      phase       <= '0;
      inc_reg     <= phase_inc;
      gain        <= GAIN_ONE;
      div_cnt     <= '0;
      period_wrap <= 1'b0;
    end else if (state != IDLE) begin
      {period_wrap, phase} <= {1'b0, phase} + {1'b0, inc_reg};
      if (state == PLAY) begin
        if (note_off) div_cnt <= '0;
      end else if (decay_tick) begin
        gain    <= gain_dec;
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end else begin
      period_wrap <= 1'b0;
    end
  end

  // ------------------------------------------------------------ table
  // Asynchronous read feeds the stage-1 register, so a same-cycle write to
  // the segment being read returns the old word.
  always_ff @(posedge clock) begin
    if (tbl_we) mem[tbl_addr] <= tbl_wdata;
  end

  assign seg        = phase[PHASE_W-1 -: SEG_ADDR_W];
  assign seg_active = ({1'b0, seg} < ACT_LIM);

  // ---------------------------------------------------------- stage 1
  always_ff @(posedge clock) begin
    if (reset || state == IDLE) begin
      s1_smp  <= '0;
      s1_gain <= '0;
    end else begin
      s1_smp  <= seg_active ? mem[seg] : '0;
      s1_gain <= gain;
    end
  end

  // ---------------------------------------------------------- stage 2
  // |sample| * 2**ENV_W fits in PW bits, so the product never overflows and
  // unity gain reproduces the sample exactly after the shift.
  assign smp_x  = PW'(s1_smp);
  assign gain_x = PW'({1'b0, s1_gain});
  assign prod   = smp_x * gain_x;

  always_ff @(posedge clock) begin
    if (reset) audio_out <= '0;
    else       audio_out <= DATA_W'(prod >>> ENV_W);
  end

endmodule

// File: tb/tb_wavetable_voice.sv
// tb_wavetable_voice
//   Drives two voices from the same stimulus: u_full plays all 64 segments,
//   u_part plays only segments 0..39. Both use a fast release (shift 2,
//   one step per clock). A behavioural model predicts the stage-1 sample
//   each clock; the prediction is queued and compared when it reaches
//   audio_out one clock later.
module tb_wavetable_voice;

  logic        clock;
  logic        reset;
  logic        note_on, note_off;
  logic [23:0] phase_inc;
  logic        tbl_we;
  logic [5:0]  tbl_addr;
  logic [31:0] tbl_wdata;
  logic [31:0] audio_a, audio_b;
  logic        busy_a, busy_b, wrap_a, wrap_b;

  int tests = 0;
  int fails = 0;

  wavetable_voice #(.DATA_W(32), .SEG_ADDR_W(6), .ACTIVE_SEGS(64), .PHASE_W(24),
                    .ENV_W(16), .DECAY_SHIFT(2), .DECAY_DIV(1)) u_full (
    .clock(clock), .reset(reset), .note_on(note_on), .note_off(note_off),
    .phase_inc(phase_inc), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .audio_out(audio_a), .busy(busy_a), .period_wrap(wrap_a));

  wavetable_voice #(.DATA_W(32), .SEG_ADDR_W(6), .ACTIVE_SEGS(40), .PHASE_W(24),
                    .ENV_W(16), .DECAY_SHIFT(2), .DECAY_DIV(1)) u_part (
    .clock(clock), .reset(reset), .note_on(note_on), .note_off(note_off),
    .phase_inc(phase_inc), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .audio_out(audio_b), .busy(busy_b), .period_wrap(wrap_b));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // model state
  int          m_state;   // 0 idle, 1 play, 2 release
  logic [23:0] m_phase, m_inc;
  int          m_gain;
  logic        m_wrap;
  logic [31:0] m_mem [64];
  logic [31:0] qa [$];
  logic [31:0] qb [$];

  function automatic logic [31:0] scale(input logic signed [31:0] s, input int g);
    longint p;
    p = longint'(s) * longint'(g);
    return 32'(p >>> 16);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $display("FAIL %s t=%0t got=%0d (0x%08h) exp=%0d (0x%08h)", tag, $time, got, got, exp, exp);
      $error("check %s", tag);
    end
  endtask

  // One clock: update the model with the inputs seen at the edge, then
  // compare outputs 1 time unit later.
  task automatic tick();
    logic [31:0] ea, eb;
    logic [5:0]  seg;
    logic [24:0] sum;
    int          dec;
    @(posedge clock);
    if (reset) begin
      m_state = 0; m_phase = '0; m_inc = '0; m_gain = 0; m_wrap = 1'b0;
      qa.delete(); qb.delete();
      qa.push_back(32'd0); qb.push_back(32'd0);
    end else begin
      seg = m_phase[23:18];
      ea = (m_state == 0) ? 32'd0 : scale(m_mem[seg], m_gain);
      eb = (m_state == 0 || seg >= 6'd40) ? 32'd0 : scale(m_mem[seg], m_gain);
      qa.push_back(ea); qb.push_back(eb);
      if (note_on) begin
        m_state = 1; m_inc = phase_inc; m_phase = '0; m_gain = 65536; m_wrap = 1'b0;
      end else if (m_state != 0) begin
        sum = {1'b0, m_phase} + {1'b0, m_inc};
        m_phase = sum[23:0];
        m_wrap  = sum[24];
        if (m_state == 1) begin
          if (note_off) m_state = 2;
        end else begin
          dec = m_gain >> 2;
          if (dec < 1) dec = 1;
          m_gain = m_gain - dec;
          if (m_gain == 0) m_state = 0;
        end
      end else begin
        m_wrap = 1'b0;
      end
    end
    if (tbl_we) m_mem[tbl_addr] = tbl_wdata;
    #1;
    if (reset) begin
      chk("audio_rst_full", audio_a, 32'd0);
      chk("audio_rst_part", audio_b, 32'd0);
      chk("busy_rst", 32'(busy_a | busy_b), 32'd0);
      chk("wrap_rst", 32'(wrap_a | wrap_b), 32'd0);
    end else begin
      ea = qa.pop_front();
      eb = qb.pop_front();
      chk("audio_full", audio_a, ea);
      chk("audio_part", audio_b, eb);
      chk("busy_full", 32'(busy_a), 32'(m_state != 0));
      chk("busy_part", 32'(busy_b), 32'(m_state != 0));
      chk("wrap_full", 32'(wrap_a), 32'(m_wrap));
      chk("wrap_part", 32'(wrap_b), 32'(m_wrap));
    end
    note_on = 1'b0; note_off = 1'b0; tbl_we = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    tbl_we = 1'b1; tbl_addr = a; tbl_wdata = d;
    tick();
  endtask

  initial begin
    reset = 1'b1; note_on = 1'b0; note_off = 1'b0; phase_inc = '0;
    tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0;
    run(2);
    reset = 1'b0;

    // load ramp table
    for (int i = 0; i < 64; i++) wr(6'(i), 32'(i * 1000));
    run(3);

    // ramp playback, one segment per clock, wraps every 64 clocks
    note_on = 1'b1; phase_inc = 24'h040000;
    tick();
    run(100);
    // write while playing; a negative word exercises the signed product
    wr(6'd50, 32'hFFFF_E19F);
    run(80);

    // release, then retrigger at half speed during release
    note_off = 1'b1; tick();
    run(4);
    note_on = 1'b1; phase_inc = 24'h020000; tick();
    run(140);

    // release all the way to idle, then note_off in idle is ignored
    note_off = 1'b1; tick();
    run(60);
    note_off = 1'b1; tick();
    run(3);

    // simultaneous note_on and note_off from idle: note_on wins
    note_on = 1'b1; note_off = 1'b1; phase_inc = 24'h040000; tick();
    run(20);

    // reset mid-play; table survives, replay ramp
    wr(6'd50, 32'd50000);
    reset = 1'b1; tick();
    reset = 1'b0;
    run(2);
    note_on = 1'b1; phase_inc = 24'h040000; tick();
    run(70);

    // flat table: DC hold with phase_inc=0, then release curve
    for (int i = 0; i < 64; i++) wr(6'(i), 32'd65536);
    note_on = 1'b1; phase_inc = 24'h000000; tick();
    run(6);
    note_on = 1'b1; phase_inc = 24'h040000; tick();
    run(3);
    note_off = 1'b1; tick();
    run(70);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
